// File: rtl/dqsw_sweep_pkg.sv
// Shared types and defaults for the DQSW write-leveling delay sweep controller.
package dqsw_sweep_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CLEAR,
        ST_SETTLE,
        ST_SAMPLE,
        ST_MOVE,
        ST_DONE,
        ST_FAIL
    } dqsw_sweep_state_t;

    localparam int DEF_MAX_TAPS      = 128;
    localparam int DEF_SETTLE_CYCLES = 8;
    localparam int DEF_SAMPLES       = 4;

    // A one-tap line still needs a 1-bit tap register.
    function automatic int tap_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/dqsw_sample_window.sv
// Per-tap settle/sample sequencer: waits SETTLE_CYCLES after start, then ANDs/ORs
// RX data over SAMPLES cycles and flags the last settle and last sample cycles.
module dqsw_sample_window
    import dqsw_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLES       = DEF_SAMPLES
)(
    input  logic       clk,
    input  logic       srst,
    input  logic       start,
    input  logic       abort,
    input  logic [1:0] rx_data,
    output logic       settle_done,
    output logic       window_done,
    output logic       all_one,
    output logic       all_zero
);

    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {PH_IDLE, PH_SETTLE, PH_SAMPLE} phase_t;

    phase_t             phase_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               last_settle;
    logic               last_sample;
    logic [1:0]         and_bits;
    logic [1:0]         or_bits;

    assign last_settle = (phase_reg == PH_SETTLE) && (cnt_reg == CNT_W'(SETTLE_CYCLES - 1));
    assign last_sample = (phase_reg == PH_SAMPLE) && (cnt_reg == CNT_W'(SAMPLES - 1));

    assign settle_done = last_settle;
    assign window_done = last_sample;

    // Results include the current cycle's data so the decision lands on the last sample edge.
    assign all_one  = &and_bits;
    assign all_zero = ~(|or_bits);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bit
        logic and_bit_reg;
        logic or_bit_reg;

        assign and_bits[gi] = and_bit_reg & rx_data[gi];
        assign or_bits[gi]  = or_bit_reg | rx_data[gi];

        always_ff @(posedge clk) begin
            if (srst || last_settle) begin
                and_bit_reg <= 1'b1;
                or_bit_reg  <= 1'b0;
            end else if (phase_reg == PH_SAMPLE) begin
                and_bit_reg <= and_bits[gi];
                or_bit_reg  <= or_bits[gi];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst || abort) begin
            phase_reg <= PH_IDLE;
            cnt_reg   <= '0;
        end else if (start) begin
            phase_reg <= PH_SETTLE;
            cnt_reg   <= '0;
        end else begin
            case (phase_reg)
                PH_SETTLE: begin
                    if (last_settle) begin
                        phase_reg <= PH_SAMPLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                PH_SAMPLE: begin
                    if (last_sample) begin
                        phase_reg <= PH_IDLE;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    phase_reg <= PH_IDLE;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dqsw_delay_sweep_ctrl.sv
// DQSW lane write-leveling trainer: sweeps the IOD delay line upward from tap 0
// and stops at the first tap whose feedback turns from stable 0 to stable 1.
module dqsw_delay_sweep_ctrl
    import dqsw_sweep_pkg::*;
#(
    parameter int MAX_TAPS      = DEF_MAX_TAPS,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int SAMPLES       = DEF_SAMPLES
)(
    input  logic                              FAB_CLK,
    input  logic                              RESET,
    input  logic                              START,
    output logic                              BUSY,
    output logic                              DONE,
    output logic                              FAIL,
    output logic [tap_width(MAX_TAPS)-1:0]    TAP_VALUE,
    output logic                              EARLY_STATUS,
    output logic                              LATE_STATUS,
    input  logic [1:0]                        RX_DATA_0,
    input  logic                              EYE_MONITOR_EARLY_0,
    input  logic                              EYE_MONITOR_LATE_0,
    input  logic                              DELAY_LINE_OUT_OF_RANGE_0,
    output logic                              DELAY_LINE_LOAD_0,
    output logic                              DELAY_LINE_MOVE_0,
    output logic                              DELAY_LINE_DIRECTION_0,
    output logic                              EYE_MONITOR_CLEAR_FLAGS_0
);

    localparam int                TAP_W    = tap_width(MAX_TAPS);
    localparam logic [TAP_W-1:0]  LAST_TAP = TAP_W'(MAX_TAPS - 1);

    dqsw_sweep_state_t  state_reg;
    logic [TAP_W-1:0]   tap_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               fail_reg;
    logic               early_reg;
    logic               late_reg;
    logic               load_reg;
    logic               move_reg;
    logic               dir_reg;
    logic               clear_reg;
    logic               seen_zero_reg;

    logic               in_window;
    logic               range_err;
    logic               settle_done;
    logic               window_done;
    logic               all_one;
    logic               all_zero;

    assign in_window = (state_reg == ST_CLEAR) || (state_reg == ST_SETTLE) ||
                       (state_reg == ST_SAMPLE);
    assign range_err = in_window && DELAY_LINE_OUT_OF_RANGE_0;

    dqsw_sample_window #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .SAMPLES       (SAMPLES)
    ) u_window (
        .clk         (FAB_CLK),
        .srst        (RESET),
        .start       (state_reg == ST_CLEAR),
        .abort       (range_err),
        .rx_data     (RX_DATA_0),
        .settle_done (settle_done),
        .window_done (window_done),
        .all_one     (all_one),
        .all_zero    (all_zero)
    );

    always_ff @(posedge FAB_CLK) begin
        if (RESET) begin
            state_reg     <= ST_IDLE;
            tap_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            fail_reg      <= 1'b0;
            early_reg     <= 1'b0;
            late_reg      <= 1'b0;
            load_reg      <= 1'b0;
            move_reg      <= 1'b0;
            dir_reg       <= 1'b0;
            clear_reg     <= 1'b0;
            seen_zero_reg <= 1'b0;
        end else begin
            load_reg  <= 1'b0;
            move_reg  <= 1'b0;
            dir_reg   <= 1'b0;
            clear_reg <= 1'b0;

            case (state_reg)
                ST_IDLE, ST_DONE, ST_FAIL: begin
                    if (START) begin
                        done_reg      <= 1'b0;
                        fail_reg      <= 1'b0;
                        seen_zero_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        load_reg      <= 1'b1;
                        tap_reg       <= '0;
                        state_reg     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    clear_reg <= 1'b1;
                    state_reg <= ST_CLEAR;
                end
                ST_CLEAR, ST_SETTLE: begin
                    if (range_err) begin
                        busy_reg  <= 1'b0;
                        fail_reg  <= 1'b1;
                        state_reg <= ST_FAIL;
                    end else if (state_reg == ST_CLEAR) begin
                        state_reg <= ST_SETTLE;
                    end else if (settle_done) begin
                        state_reg <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    // Range error wins over a same-cycle transition decision.
                    if (range_err) begin
                        busy_reg  <= 1'b0;
                        fail_reg  <= 1'b1;
                        state_reg <= ST_FAIL;
                    end else if (window_done) begin
                        early_reg <= EYE_MONITOR_EARLY_0;
                        late_reg  <= EYE_MONITOR_LATE_0;
                        if (all_one && seen_zero_reg) begin
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end else begin
                            if (all_zero) begin
                                seen_zero_reg <= 1'b1;
                            end
                            // Checking the last tap before moving keeps the tap from wrapping.
                            if (tap_reg == LAST_TAP) begin
                                busy_reg  <= 1'b0;
                                fail_reg  <= 1'b1;
                                state_reg <= ST_FAIL;
                            end else begin
                                move_reg  <= 1'b1;
                                dir_reg   <= 1'b1;
                                tap_reg   <= tap_reg + TAP_W'(1);
                                state_reg <= ST_MOVE;
                            end
                        end
                    end
                end
                ST_MOVE: begin
                    clear_reg <= 1'b1;
                    state_reg <= ST_CLEAR;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign BUSY                      = busy_reg;
    assign DONE                      = done_reg;
    assign FAIL                      = fail_reg;
    assign TAP_VALUE                 = tap_reg;
    assign EARLY_STATUS              = early_reg;
    assign LATE_STATUS               = late_reg;
    assign DELAY_LINE_LOAD_0         = load_reg;
    assign DELAY_LINE_MOVE_0         = move_reg;
    assign DELAY_LINE_DIRECTION_0    = dir_reg;
    assign EYE_MONITOR_CLEAR_FLAGS_0 = clear_reg;

endmodule

// File: tb/tb_dqsw_delay_sweep_ctrl.sv
// Directed bench for the DQSW delay sweep controller with an 8-tap line and default
// settle/sample lengths (14 cycles per tap, tap-k CLEAR at cycle 2+14k).
module tb_dqsw_delay_sweep_ctrl;
    import dqsw_sweep_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, fail;
    logic [2:0]  tap;
    logic        early_st, late_st;
    logic [1:0]  rx;
    logic        eye_early, eye_late, oor;
    logic        dl_load, dl_move, dl_dir, clr_flags;
    logic [11:0] outs;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int n_load, n_move, n_dir, n_clear;

    always #5 clk = ~clk;

    assign outs = {busy, done, fail, early_st, late_st, dl_load, dl_move, dl_dir, clr_flags, tap};

    dqsw_delay_sweep_ctrl #(
        .MAX_TAPS      (8),
        .SETTLE_CYCLES (8),
        .SAMPLES       (4)
    ) dut (
        .FAB_CLK                   (clk),
        .RESET                     (rst),
        .START                     (start),
        .BUSY                      (busy),
        .DONE                      (done),
        .FAIL                      (fail),
        .TAP_VALUE                 (tap),
        .EARLY_STATUS              (early_st),
        .LATE_STATUS               (late_st),
        .RX_DATA_0                 (rx),
        .EYE_MONITOR_EARLY_0       (eye_early),
        .EYE_MONITOR_LATE_0        (eye_late),
        .DELAY_LINE_OUT_OF_RANGE_0 (oor),
        .DELAY_LINE_LOAD_0         (dl_load),
        .DELAY_LINE_MOVE_0         (dl_move),
        .DELAY_LINE_DIRECTION_0    (dl_dir),
        .EYE_MONITOR_CLEAR_FLAGS_0 (clr_flags)
    );

    // Feedback data for cycle c; tap k spans cycles 2+14k..15+14k, samples at phase 9..12.
    function automatic logic [1:0] rx_pattern(input int mode, input int c);
        int t;
        int ph;
        t  = (c >= 2) ? (c - 2) / 14 : 0;
        ph = (c >= 2) ? (c - 2) % 14 : 0;
        case (mode)
            0: return (t < 5) ? 2'b00 : 2'b11;
            1: return 2'b11;
            2: return 2'b00;
            3: begin
                if (t < 2) return 2'b00;
                else if (t == 2 && ph == 9) return 2'b01;
                else return 2'b11;
            end
            default: return (t < 2) ? 2'b00 : 2'b11;
        endcase
    endfunction

    task automatic step(input int mode);
        @(posedge clk);
        #1;
        cyc++;
        if (dl_load)   n_load++;
        if (dl_move)   n_move++;
        if (dl_dir)    n_dir++;
        if (clr_flags) n_clear++;
        rx = rx_pattern(mode, cyc);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        oor = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic begin_sweep(input int mode);
        n_load = 0; n_move = 0; n_dir = 0; n_clear = 0;
        cyc = 0;
        start = 1'b1;
        rx = rx_pattern(mode, 0);
        step(mode);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rx = 2'b00; oor = 1'b0; eye_early = 1'b0; eye_late = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (outs !== 12'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 000", outs); end
        n_checks++; if (dut.state_reg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state_reg, ST_IDLE); end
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_no_start_busy: got %0b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_transition_tap5();
        do_reset();
        eye_early = 1'b1; eye_late = 1'b0;
        begin_sweep(0);
        n_checks++; if ({dl_load, busy, tap} !== 5'b11000) begin n_fail++; $display("FAIL tap5_load_cycle1: got %b expected 11000", {dl_load, busy, tap}); end
        while (cyc < 85) begin
            step(0);
            if (cyc == 2) begin
                n_checks++; if ({clr_flags, tap} !== 4'b1000) begin n_fail++; $display("FAIL tap5_clear_cycle2: got %b expected 1000", {clr_flags, tap}); end
            end
            if (cyc == 84) begin
                n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL tap5_done_early: got %0b expected 0", done); end
            end
        end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL tap5_done: got %0b expected 1", done); end
        n_checks++; if (tap !== 3'd5) begin n_fail++; $display("FAIL tap5_tap: got %0d expected 5", tap); end
        n_checks++; if ({busy, fail} !== 2'b00) begin n_fail++; $display("FAIL tap5_busy_fail: got %b expected 00", {busy, fail}); end
        n_checks++; if ({early_st, late_st} !== 2'b10) begin n_fail++; $display("FAIL tap5_status: got %b expected 10", {early_st, late_st}); end
        n_checks++; if (n_load !== 1) begin n_fail++; $display("FAIL tap5_load_count: got %0d expected 1", n_load); end
        n_checks++; if (n_move !== 5) begin n_fail++; $display("FAIL tap5_move_count: got %0d expected 5", n_move); end
        n_checks++; if (n_dir !== 5) begin n_fail++; $display("FAIL tap5_dir_count: got %0d expected 5", n_dir); end
        n_checks++; if (n_clear !== 6) begin n_fail++; $display("FAIL tap5_clear_count: got %0d expected 6", n_clear); end
        $display("test_transition_tap5 done at cycle %0d tap %0d", cyc, tap);
    endtask

    task automatic test_no_zero();
        do_reset();
        eye_early = 1'b0; eye_late = 1'b1;
        begin_sweep(1);
        while (cyc < 113) begin
            step(1);
            if (cyc == 112) begin
                n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL nozero_fail_early: got %0b expected 0", fail); end
            end
        end
        n_checks++; if ({fail, done, busy} !== 3'b100) begin n_fail++; $display("FAIL nozero_flags: got %b expected 100", {fail, done, busy}); end
        n_checks++; if (tap !== 3'd7) begin n_fail++; $display("FAIL nozero_tap: got %0d expected 7", tap); end
        n_checks++; if (n_move !== 7) begin n_fail++; $display("FAIL nozero_move_count: got %0d expected 7", n_move); end
        n_checks++; if ({early_st, late_st} !== 2'b01) begin n_fail++; $display("FAIL nozero_status: got %b expected 01", {early_st, late_st}); end
        repeat (20) step(1);
        n_checks++; if ({fail, tap} !== 4'b1111) begin n_fail++; $display("FAIL nozero_hold: got %b expected 1111", {fail, tap}); end
        n_checks++; if (n_move !== 7) begin n_fail++; $display("FAIL nozero_no_wrap_move: got %0d expected 7", n_move); end
        $display("test_no_zero done at cycle %0d tap %0d", cyc, tap);
    endtask

    task automatic test_out_of_range();
        do_reset();
        begin_sweep(2);
        while (cyc < 48) begin
            step(2);
            if (cyc == 47) begin
                n_checks++; if (fail !== 1'b0) begin n_fail++; $display("FAIL oor_fail_early: got %0b expected 0", fail); end
                oor = 1'b1;
            end
        end
        oor = 1'b0;
        n_checks++; if ({fail, busy, done} !== 3'b100) begin n_fail++; $display("FAIL oor_flags: got %b expected 100", {fail, busy, done}); end
        n_checks++; if (tap !== 3'd3) begin n_fail++; $display("FAIL oor_tap: got %0d expected 3", tap); end
        repeat (30) step(2);
        n_checks++; if (n_move !== 3) begin n_fail++; $display("FAIL oor_move_count: got %0d expected 3", n_move); end
        n_checks++; if ({fail, tap} !== 4'b1011) begin n_fail++; $display("FAIL oor_hold: got %b expected 1011", {fail, tap}); end
        $display("test_out_of_range done at cycle %0d tap %0d", cyc, tap);
    endtask

    task automatic test_mixed();
        do_reset();
        begin_sweep(3);
        while (cyc < 57) begin
            step(3);
            if (cyc == 43) begin
                n_checks++; if ({done, busy} !== 2'b01) begin n_fail++; $display("FAIL mixed_tap2_undecided: got %b expected 01", {done, busy}); end
            end
        end
        n_checks++; if ({done, fail} !== 2'b10) begin n_fail++; $display("FAIL mixed_done: got %b expected 10", {done, fail}); end
        n_checks++; if (tap !== 3'd3) begin n_fail++; $display("FAIL mixed_tap: got %0d expected 3", tap); end
        $display("test_mixed done at cycle %0d tap %0d", cyc, tap);
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        eye_early = 1'b1; eye_late = 1'b1;
        begin_sweep(2);
        while (cyc < 68) step(2);
        n_checks++; if ({busy, tap} !== 4'b1100) begin n_fail++; $display("FAIL midrst_before: got %b expected 1100", {busy, tap}); end
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        n_checks++; if (outs !== 12'd0) begin n_fail++; $display("FAIL midrst_outputs: got %h expected 000", outs); end
        n_checks++; if (dut.state_reg !== ST_IDLE) begin n_fail++; $display("FAIL midrst_state: got %0d expected %0d", dut.state_reg, ST_IDLE); end
        repeat (3) step(2);
        n_checks++; if ({busy, dl_move} !== 2'b00) begin n_fail++; $display("FAIL midrst_stays_idle: got %b expected 00", {busy, dl_move}); end
        begin_sweep(2);
        n_checks++; if ({dl_load, busy, tap} !== 5'b11000) begin n_fail++; $display("FAIL midrst_restart_load: got %b expected 11000", {dl_load, busy, tap}); end
        $display("test_reset_mid_sweep done");
    endtask

    task automatic test_start_handling();
        do_reset();
        begin_sweep(4);
        while (cyc < 43) begin
            step(4);
            start = ((cyc >= 5 && cyc < 8) || cyc == 20) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        n_checks++; if ({done, tap} !== 4'b1010) begin n_fail++; $display("FAIL start_busy_ignored_done: got %b expected 1010", {done, tap}); end
        n_checks++; if (n_load !== 1) begin n_fail++; $display("FAIL start_busy_load_count: got %0d expected 1", n_load); end
        start = 1'b1;
        step(4);
        start = 1'b0;
        n_checks++; if ({done, dl_load, busy, tap} !== 6'b011000) begin n_fail++; $display("FAIL start_in_done: got %b expected 011000", {done, dl_load, busy, tap}); end
        step(4);
        n_checks++; if ({clr_flags, busy} !== 2'b11) begin n_fail++; $display("FAIL start_restart_clear: got %b expected 11", {clr_flags, busy}); end
        $display("test_start_handling done");
    endtask

    initial begin
        test_reset();
        test_transition_tap5();
        test_no_zero();
        test_out_of_range();
        test_mixed();
        test_reset_mid_sweep();
        test_start_handling();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
